fabric_arbiter: RTL and testbench

- N-to-1 fabric request arbiter with response demultiplexer; shares one downstream fabric slave between NUM_M upstream fabric masters.
- Tags each forwarded request ID with the master index. Routes responses back by that tag and strips it.
- Sits between CPU/DMA/accelerator fabric masters and a shared memory or IO slave port.
- Round-robin fairness, a per-master outstanding limit, and a grant lock that keeps the downstream request stable under backpressure.

---
 rtl/carbon_arch_pkg.sv | 4 +
 rtl/carbon_fabric_arb_pkg.sv | 13 +
 rtl/fabric_arbiter_rr_pick.sv | 28 ++
 rtl/fabric_arbiter.sv | 149 ++++++++++++++
 tb/tb_fabric_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/carbon_arch_pkg.sv
// Architecture-wide fabric constants shared by fabric blocks.
package carbon_arch_pkg;
    localparam int CARBON_FABRIC_ATTR_WIDTH_BITS = 8;
endpackage

// File: rtl/carbon_fabric_arb_pkg.sv
// Shared types and helpers for the fabric request arbiter.
package carbon_fabric_arb_pkg;
    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int FABRIC_ARB_MAX_M = 16;

    function automatic int arb_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fabric_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first eligible index at or above rr_ptr, with wrap.
module fabric_rr_pick
    import carbon_fabric_arb_pkg::*;
#(
    parameter  int NUM_M = 4,
    localparam int IDX_W = arb_idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);
    int idx;

    // Walk from the farthest slot down so the nearest eligible master overwrites last.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_M;
            if (eligible[idx]) begin
                grant = IDX_W'(idx);
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fabric_arbiter.sv
// N-to-1 fabric request arbiter with ID tagging and tag-routed response demultiplexing.
module fabric_arbiter
    import carbon_fabric_arb_pkg::*;
#(
    parameter  int NUM_M     = 4,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int ID_W      = 4,
    parameter  int OP_W      = 8,
    parameter  int SIZE_W    = 3,
    parameter  int ATTR_W    = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter  int CODE_W    = 8,
    parameter  int MAX_OUTST = 4,
    localparam int IDX_W     = arb_idx_w(NUM_M),
    localparam int S_ID_W    = ID_W + IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M-1:0]           m_req_valid,
    output logic [NUM_M-1:0]           m_req_ready,
    input  logic [NUM_M*OP_W-1:0]      m_req_op,
    input  logic [NUM_M*ADDR_W-1:0]    m_req_addr,
    input  logic [NUM_M*DATA_W-1:0]    m_req_wdata,
    input  logic [NUM_M*DATA_W/8-1:0]  m_req_wstrb,
    input  logic [NUM_M*SIZE_W-1:0]    m_req_size,
    input  logic [NUM_M*ATTR_W-1:0]    m_req_attr,
    input  logic [NUM_M*ID_W-1:0]      m_req_id,
    output logic [NUM_M-1:0]           m_rsp_valid,
    input  logic [NUM_M-1:0]           m_rsp_ready,
    output logic [NUM_M*DATA_W-1:0]    m_rsp_rdata,
    output logic [NUM_M*CODE_W-1:0]    m_rsp_code,
    output logic [NUM_M*ID_W-1:0]      m_rsp_id,
    output logic                       s_req_valid,
    input  logic                       s_req_ready,
    output logic [OP_W-1:0]            s_req_op,
    output logic [ADDR_W-1:0]          s_req_addr,
    output logic [DATA_W-1:0]          s_req_wdata,
    output logic [DATA_W/8-1:0]        s_req_wstrb,
    output logic [SIZE_W-1:0]          s_req_size,
    output logic [ATTR_W-1:0]          s_req_attr,
    output logic [S_ID_W-1:0]          s_req_id,
    input  logic                       s_rsp_valid,
    output logic                       s_rsp_ready,
    input  logic [DATA_W-1:0]          s_rsp_rdata,
    input  logic [CODE_W-1:0]          s_rsp_code,
    input  logic [S_ID_W-1:0]          s_rsp_id,
    output logic [NUM_M*4-1:0]         outst_cnt,
    output logic                       err_unexp_rsp
);
    localparam int SEL_N = 1 << IDX_W;
    localparam int WS_W  = DATA_W / 8;

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, grant_q, pick_idx, grant, sel;
    logic             pick_any, req_fire, rsp_fire, sel_ok;
    logic [3:0]       cnt [NUM_M];
    logic [NUM_M-1:0] eligible, inc, dec, zero;
    logic [SEL_N-1:0] sel_legal;
    int               gidx;

    for (genvar j = 0; j < SEL_N; j++) begin : g_sel_legal
        assign sel_legal[j] = (j < NUM_M);
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_M; i++) begin
            eligible[i] = m_req_valid[i] && (cnt[i] < 4'(MAX_OUTST));
        end
    end

    fabric_rr_pick #(.NUM_M(NUM_M)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (pick_idx),
        .any      (pick_any)
    );

    // Request side: grant selection, lock FSM and payload mux.
    always_comb begin
        state_nxt   = state;
        grant       = (state == ARB_LOCKED) ? grant_q : pick_idx;
        s_req_valid = !rst && ((state == ARB_LOCKED) || pick_any);
        req_fire    = s_req_valid && s_req_ready;
        m_req_ready = '0;
        if (req_fire) m_req_ready[grant] = 1'b1;
        case (state)
            ARB_IDLE:   if (s_req_valid && !s_req_ready) state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (s_req_ready) state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        gidx        = int'(grant);
        s_req_op    = m_req_op[gidx*OP_W +: OP_W];
        s_req_addr  = m_req_addr[gidx*ADDR_W +: ADDR_W];
        s_req_wdata = m_req_wdata[gidx*DATA_W +: DATA_W];
        s_req_wstrb = m_req_wstrb[gidx*WS_W +: WS_W];
        s_req_size  = m_req_size[gidx*SIZE_W +: SIZE_W];
        s_req_attr  = m_req_attr[gidx*ATTR_W +: ATTR_W];
        s_req_id    = {grant, m_req_id[gidx*ID_W +: ID_W]};
    end

    // Response side: route by tag; tags beyond NUM_M are drained and flagged.
    always_comb begin
        sel         = s_rsp_id[S_ID_W-1:ID_W];
        sel_ok      = sel_legal[sel];
        m_rsp_valid = '0;
        if (!rst && s_rsp_valid && sel_ok) m_rsp_valid[sel] = 1'b1;
        s_rsp_ready = !rst && (sel_ok ? m_rsp_ready[sel] : 1'b1);
        rsp_fire    = s_rsp_valid && s_rsp_ready;
        m_rsp_rdata = {NUM_M{s_rsp_rdata}};
        m_rsp_code  = {NUM_M{s_rsp_code}};
        m_rsp_id    = {NUM_M{s_rsp_id[ID_W-1:0]}};
    end

    always_comb begin
        inc       = '0;
        dec       = '0;
        zero      = '0;
        outst_cnt = '0;
        for (int i = 0; i < NUM_M; i++) begin
            inc[i]           = req_fire && (grant == IDX_W'(i));
            dec[i]           = rsp_fire && sel_ok && (sel == IDX_W'(i));
            zero[i]          = (cnt[i] == 4'd0);
            outst_cnt[i*4 +: 4] = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            rr_ptr        <= '0;
            grant_q       <= '0;
            err_unexp_rsp <= 1'b0;
            for (int i = 0; i < NUM_M; i++) cnt[i] <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE) grant_q <= pick_idx;
            if (req_fire) rr_ptr <= (int'(grant) == NUM_M - 1) ? '0 : grant + 1'b1;
            for (int i = 0; i < NUM_M; i++) begin
                if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 4'd1;
                else if (!inc[i] && dec[i] && !zero[i]) cnt[i] <= cnt[i] - 4'd1;
            end
            if (rsp_fire && (!sel_ok || |(dec & zero))) err_unexp_rsp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fabric_arbiter.sv
// Bench for fabric_arbiter: reset/table checks, directed corner sequences, randomized traffic vs. a reference model.
module tb_fabric_arbiter;
    localparam int NM = 4, AW = 32, DW = 32, IW = 4, OW = 8, SW = 3, CW = 8, MO = 4;
    localparam int TW = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS;
    localparam int SIW = IW + 2;

    logic              clk, rst;
    logic [NM-1:0]     m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready;
    logic [NM*OW-1:0]  m_req_op;
    logic [NM*AW-1:0]  m_req_addr;
    logic [NM*DW-1:0]  m_req_wdata, m_rsp_rdata;
    logic [NM*DW/8-1:0] m_req_wstrb;
    logic [NM*SW-1:0]  m_req_size;
    logic [NM*TW-1:0]  m_req_attr;
    logic [NM*IW-1:0]  m_req_id, m_rsp_id;
    logic [NM*CW-1:0]  m_rsp_code;
    logic              s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [OW-1:0]     s_req_op;
    logic [AW-1:0]     s_req_addr;
    logic [DW-1:0]     s_req_wdata, s_rsp_rdata;
    logic [DW/8-1:0]   s_req_wstrb;
    logic [SW-1:0]     s_req_size;
    logic [TW-1:0]     s_req_attr;
    logic [SIW-1:0]    s_req_id, s_rsp_id;
    logic [CW-1:0]     s_rsp_code;
    logic [NM*4-1:0]   outst_cnt;
    logic              err_unexp_rsp;

    fabric_arbiter #(
        .NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .OP_W(OW), .SIZE_W(SW),
        .ATTR_W(TW), .CODE_W(CW), .MAX_OUTST(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_op(m_req_op),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_req_size(m_req_size), .m_req_attr(m_req_attr), .m_req_id(m_req_id),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_code(m_rsp_code), .m_rsp_id(m_rsp_id),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_op(s_req_op),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
        .s_req_size(s_req_size), .s_req_attr(s_req_attr), .s_req_id(s_req_id),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_code(s_rsp_code), .s_rsp_id(s_rsp_id),
        .outst_cnt(outst_cnt), .err_unexp_rsp(err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_rr, m_lockg;
    int m_cnt [NM];
    bit m_locked, m_err;
    logic [SIW-1:0] rspq [$];

    typedef struct packed {
        logic          v;
        logic [SIW-1:0] id;
        logic [NM-1:0] rdy;
        logic [NM-1:0] e_mv;
        logic          e_sr;
        logic [IW-1:0] e_mid;
    } rsp_vec_t;
    rsp_vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m_req_valid = '0; m_req_op = '0; m_req_addr = '0; m_req_wdata = '0;
        m_req_wstrb = '0; m_req_size = '0; m_req_attr = '0; m_req_id = '0;
        m_rsp_ready = '0; s_req_ready = 1'b0; s_rsp_valid = 1'b0;
        s_rsp_rdata = '0; s_rsp_code = '0; s_rsp_id = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [IW-1:0] id);
        m_req_valid[i] = 1'b1;
        m_req_addr[i*AW +: AW] = addr;
        m_req_id[i*IW +: IW] = id;
        m_req_op[i*OW +: OW] = OW'(i + 1);
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_rr = 0; m_locked = 0; m_lockg = 0; m_err = 0;
        for (int i = 0; i < NM; i++) m_cnt[i] = 0;
        rspq.delete();
    endtask

    function automatic logic [3:0] cnt_of(input int i);
        return outst_cnt[i*4 +: 4];
    endfunction

    function automatic int model_pick(input logic [NM-1:0] v);
        for (int k = 0; k < NM; k++) begin
            int i;
            i = (m_rr + k) % NM;
            if (v[i] && m_cnt[i] < MO) return i;
        end
        return -1;
    endfunction

    initial begin
        int g, sel, clr_g;
        bit ev, efire, rfire, clr_rsp;
        logic [NM*4-1:0] exp_cnt;

        // Reset: outputs held low even with everything requesting
        clear_inputs();
        rst = 1'b1;
        m_req_valid = '1; s_req_ready = 1'b1; s_rsp_valid = 1'b1; m_rsp_ready = '1;
        tick();
        tick();
        chk("rst_s_req_valid", s_req_valid, 0);
        chk("rst_m_req_ready", m_req_ready, 0);
        chk("rst_m_rsp_valid", m_rsp_valid, 0);
        chk("rst_s_rsp_ready", s_rsp_ready, 0);
        chk("rst_outst_cnt", outst_cnt, 0);
        chk("rst_err", err_unexp_rsp, 0);
        do_reset();

        // Response routing table (none of these complete a handshake)
        tbl[0] = '{v:1'b1, id:6'h05, rdy:4'b1110, e_mv:4'b0001, e_sr:1'b0, e_mid:4'h5};
        tbl[1] = '{v:1'b1, id:6'h32, rdy:4'b0111, e_mv:4'b1000, e_sr:1'b0, e_mid:4'h2};
        tbl[2] = '{v:1'b1, id:6'h1F, rdy:4'b1101, e_mv:4'b0010, e_sr:1'b0, e_mid:4'hF};
        tbl[3] = '{v:1'b0, id:6'h2A, rdy:4'b1111, e_mv:4'b0000, e_sr:1'b1, e_mid:4'hA};
        for (int t = 0; t < 4; t++) begin
            s_rsp_valid = tbl[t].v; s_rsp_id = tbl[t].id; m_rsp_ready = tbl[t].rdy;
            #1;
            chk("tbl_m_rsp_valid", m_rsp_valid, tbl[t].e_mv);
            chk("tbl_s_rsp_ready", s_rsp_ready, tbl[t].e_sr);
            chk("tbl_m_rsp_id", m_rsp_id, {NM{tbl[t].e_mid}});
        end
        clear_inputs();
        tick();
        chk("tbl_no_side_effect", {err_unexp_rsp, outst_cnt}, 0);

        // Single request passes through in the same cycle
        do_reset();
        set_req(2, 32'h1000, 4'd3); s_req_ready = 1'b1;
        #1;
        chk("t1_s_req_valid", s_req_valid, 1);
        chk("t1_s_req_id", s_req_id, 6'h23);
        chk("t1_m_req_ready", m_req_ready, 4'b0100);
        chk("t1_s_req_addr", s_req_addr, 32'h1000);
        tick();
        m_req_valid = '0;
        chk("t1_cnt2", cnt_of(2), 1);
        set_req(0, 32'h2000, 4'd1); set_req(3, 32'h3000, 4'd2);
        #1;
        chk("t1_rr_next_is_3", s_req_id, 6'h32);
        chk("t1_m_req_ready3", m_req_ready, 4'b1000);
        tick();
        clear_inputs();

        // All masters requesting with an always-ready slave
        do_reset();
        for (int i = 0; i < NM; i++) set_req(i, 32'h100 * i, IW'(i));
        s_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t2_s_req_id", s_req_id, ((c % NM) << IW) | (c % NM));
            chk("t2_m_req_ready", m_req_ready, 1 << (c % NM));
            tick();
        end

        // Lock under backpressure
        do_reset();
        set_req(1, 32'h1111_0000, 4'd7); s_req_ready = 1'b0;
        #1;
        chk("t3_grant1", s_req_id, 6'h17);
        chk("t3_no_ready", m_req_ready, 0);
        tick();
        set_req(0, 32'h0000_AAAA, 4'd5);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_lock_valid", s_req_valid, 1);
            chk("t3_lock_id", s_req_id, 6'h17);
            chk("t3_lock_addr", s_req_addr, 32'h1111_0000);
            chk("t3_lock_no_ready", m_req_ready, 0);
            tick();
        end
        s_req_ready = 1'b1;
        #1;
        chk("t3_accept_id", s_req_id, 6'h17);
        chk("t3_accept_ready", m_req_ready, 4'b0010);
        tick();
        m_req_valid[1] = 1'b0;
        #1;
        chk("t3_next_id", s_req_id, 6'h05);
        chk("t3_next_ready", m_req_ready, 4'b0001);
        tick();
        clear_inputs();

        // Outstanding limit, then a retiring response reopens the master
        do_reset();
        set_req(0, 32'h4000, 4'd5); s_req_ready = 1'b1;
        for (int k = 0; k < MO; k++) begin
            #1;
            chk("t4_issue_ready", m_req_ready, 4'b0001);
            tick();
        end
        chk("t4_cnt0_full", cnt_of(0), MO);
        set_req(3, 32'h3000, 4'd9);
        #1;
        chk("t4_m3_served", m_req_ready, 4'b1000);
        chk("t4_m3_id", s_req_id, 6'h39);
        tick();
        m_req_valid[3] = 1'b0;
        #1;
        chk("t4_m0_blocked", s_req_valid, 0);
        s_rsp_valid = 1'b1; s_rsp_id = 6'h05; m_rsp_ready = 4'b0001;
        #1;
        chk("t4_rsp_valid", m_rsp_valid, 4'b0001);
        chk("t4_rsp_id", m_rsp_id, {NM{4'h5}});
        chk("t4_rsp_ready", s_rsp_ready, 1);
        chk("t4_retire_not_counted", s_req_valid, 0);
        tick();
        s_rsp_valid = 1'b0; m_rsp_ready = '0;
        chk("t4_cnt0_dec", cnt_of(0), MO - 1);
        #1;
        chk("t4_m0_again", m_req_ready, 4'b0001);
        chk("t4_m0_id", s_req_id, 6'h05);
        tick();
        clear_inputs();

        // Response held under upstream backpressure
        do_reset();
        set_req(3, 32'h0, 4'd2); s_req_ready = 1'b1;
        tick();
        clear_inputs();
        s_rsp_valid = 1'b1; s_rsp_id = 6'h32;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5_hold_valid", m_rsp_valid, 4'b1000);
            chk("t5_hold_ready", s_rsp_ready, 0);
            chk("t5_hold_cnt", cnt_of(3), 1);
            tick();
        end
        m_rsp_ready = 4'b1000;
        #1;
        chk("t5_accept_ready", s_rsp_ready, 1);
        chk("t5_accept_valid", m_rsp_valid, 4'b1000);
        tick();
        clear_inputs();
        chk("t5_cnt3", cnt_of(3), 0);
        chk("t5_no_err", err_unexp_rsp, 0);

        // Unexpected response sets a sticky error
        do_reset();
        s_rsp_valid = 1'b1; s_rsp_id = 6'h10; m_rsp_ready = 4'b0010;
        #1;
        chk("t6_drain_ready", s_rsp_ready, 1);
        tick();
        clear_inputs();
        chk("t6_err_set", err_unexp_rsp, 1);
        chk("t6_cnt1_zero", cnt_of(1), 0);
        tick();
        tick();
        chk("t6_err_sticky", err_unexp_rsp, 1);
        do_reset();
        chk("t6_err_cleared", err_unexp_rsp, 0);

        // Randomized traffic against the reference model
        do_reset();
        clr_g = -1; clr_rsp = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (clr_g >= 0) m_req_valid[clr_g] = 1'b0;
            if (clr_rsp) s_rsp_valid = 1'b0;
            clr_g = -1; clr_rsp = 0;
            for (int i = 0; i < NM; i++)
                if (!m_req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom, IW'($urandom_range(0, 15)));
            s_req_ready = ($urandom_range(0, 3) != 0);
            if (!s_rsp_valid && rspq.size() > 0 && $urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(0, rspq.size() - 1);
                s_rsp_id = rspq[k];
                rspq.delete(k);
                s_rsp_valid = 1'b1;
                s_rsp_rdata = $urandom;
            end
            m_rsp_ready = NM'($urandom);
            #1;
            g = m_locked ? m_lockg : model_pick(m_req_valid);
            ev = (g >= 0);
            efire = ev && s_req_ready;
            chk("rnd_s_req_valid", s_req_valid, ev);
            if (ev) begin
                chk("rnd_s_req_id", s_req_id, (g << IW) | m_req_id[g*IW +: IW]);
                chk("rnd_s_req_addr", s_req_addr, m_req_addr[g*AW +: AW]);
            end
            chk("rnd_m_req_ready", m_req_ready, efire ? (1 << g) : 0);
            sel = int'(s_rsp_id) >> IW;
            rfire = s_rsp_valid && m_rsp_ready[sel];
            chk("rnd_m_rsp_valid", m_rsp_valid, s_rsp_valid ? (1 << sel) : 0);
            chk("rnd_s_rsp_ready", s_rsp_ready, m_rsp_ready[sel]);
            chk("rnd_m_rsp_rdata", m_rsp_rdata, {NM{s_rsp_rdata}});
            exp_cnt = '0;
            for (int i = 0; i < NM; i++) exp_cnt[i*4 +: 4] = 4'(m_cnt[i]);
            chk("rnd_outst_cnt", outst_cnt, exp_cnt);
            chk("rnd_err", err_unexp_rsp, m_err);
            if (rfire) begin
                if (m_cnt[sel] == 0) m_err = 1;
                else m_cnt[sel]--;
                clr_rsp = 1;
            end
            if (efire) begin
                rspq.push_back(SIW'((g << IW) | m_req_id[g*IW +: IW]));
                m_cnt[g]++;
                m_rr = (g + 1) % NM;
                m_locked = 0;
                clr_g = g;
            end else if (ev) begin
                m_locked = 1;
                m_lockg = g;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
